// File: rtl/axi_llc_data_sched_pkg.sv
// Shared types for the LLC data SRAM scheduler.
// Optional perf counters: AXI_LLC_DATA_SCHED_PERF_EN.
package axi_llc_data_sched_pkg;

    localparam int unsigned DefNumReq    = 3;
    localparam int unsigned DefNumWords  = 1024;
    localparam int unsigned DefDataWidth = 128;
    localparam int unsigned DefByteWidth = 8;
    localparam int unsigned DefLatency   = 1;
    localparam int unsigned DefRspDepth  = 2;

    localparam int unsigned IdWidth     = $clog2(DefNumReq);
    localparam int unsigned CreditWidth = $clog2(DefRspDepth + 1);

    typedef logic [IdWidth-1:0]      id_t;
    typedef logic [DefDataWidth-1:0] data_t;

    typedef struct packed {
        id_t   id;
        data_t rdata;
    } rsp_t;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v,
                                              input logic        en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/axi_llc_data_sched_rsp_buf.sv
// Fall-through response FIFO for the LLC data SRAM scheduler.
// Optional perf counters (top only): AXI_LLC_DATA_SCHED_PERF_EN.
module axi_llc_data_sched_rsp_buf
    import axi_llc_data_sched_pkg::*;
#(
    parameter int unsigned Depth = 2,
    parameter type         buf_t = rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic push_i,
    input  buf_t data_i,
    output logic valid_o,
    input  logic ready_i,
    output buf_t data_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    buf_t            mem_q [Depth];
    logic [PtrW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            empty, full, pop, do_wr, do_rd;

    function automatic logic [PtrW-1:0] wrap_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CntW'(Depth));
    assign valid_o = push_i || !empty;
    assign data_o  = empty ? data_i : mem_q[rd_q];
    assign pop     = valid_o && ready_i;
    // An entry that arrives into an empty buffer and leaves at once is never stored.
    assign do_wr   = push_i && !(empty && pop);
    assign do_rd   = pop && !empty;

    always_comb begin
        wr_d  = do_wr ? wrap_inc(wr_q) : wr_q;
        rd_d  = do_rd ? wrap_inc(rd_q) : rd_q;
        cnt_d = cnt_q + CntW'(do_wr) - CntW'(do_rd);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_q] <= data_i;
    end

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(push_i && full));

endmodule

// File: rtl/axi_llc_data_sram_sched.sv
// Round-robin scheduler sharing one LLC data SRAM port among requesters.
// Optional perf counters: AXI_LLC_DATA_SCHED_PERF_EN.
module axi_llc_data_sram_sched
    import axi_llc_data_sched_pkg::*;
#(
    parameter int unsigned NumReq    = DefNumReq,
    parameter int unsigned NumWords  = DefNumWords,
    parameter int unsigned DataWidth = DefDataWidth,
    parameter int unsigned ByteWidth = DefByteWidth,
    parameter int unsigned Latency   = DefLatency,
    parameter int unsigned RspDepth  = DefRspDepth,
    parameter int unsigned AddrWidth = $clog2(NumWords),
    parameter int unsigned BeWidth   = (DataWidth + ByteWidth - 1) / ByteWidth,
    parameter int unsigned IdW       = $clog2(NumReq)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_valid_i,
    output logic [NumReq-1:0]                req_ready_o,
    input  logic [NumReq-1:0]                req_we_i,
    input  logic [NumReq-1:0][AddrWidth-1:0] req_addr_i,
    input  logic [NumReq-1:0][DataWidth-1:0] req_wdata_i,
    input  logic [NumReq-1:0][BeWidth-1:0]   req_be_i,
    output logic                             rsp_valid_o,
    input  logic                             rsp_ready_i,
    output logic [IdW-1:0]                   rsp_id_o,
    output logic [DataWidth-1:0]             rsp_rdata_o,
    output logic                             sram_req_o,
    output logic                             sram_we_o,
    output logic [AddrWidth-1:0]             sram_addr_o,
    output logic [DataWidth-1:0]             sram_wdata_o,
    output logic [BeWidth-1:0]               sram_be_o,
    input  logic [DataWidth-1:0]             sram_rdata_i,
    output logic [31:0]                      perf_rd_o,
    output logic [31:0]                      perf_wr_o,
    output logic [31:0]                      perf_stall_o
);

    localparam int unsigned CntW = $clog2(RspDepth + 1);

    typedef logic [IdW-1:0] rid_t;
    typedef struct packed {
        rid_t                 id;
        logic [DataWidth-1:0] rdata;
    } buf_t;

    logic [CntW-1:0]          credits_q, credits_d;
    rid_t                     rr_q, rr_d;
    logic [Latency-1:0]       pipe_vld_q, pipe_vld_d;
    rid_t [Latency-1:0]       pipe_id_q, pipe_id_d;

    logic [NumReq-1:0] eligible;
    logic              credit_ok, gnt_any, gnt, gnt_we, rd_gnt;
    rid_t              gnt_idx;
    logic              buf_valid, pop;
    buf_t              buf_in, buf_out;

    // Credits are registered so rsp_ready_i never reaches req_ready_o.
    assign credit_ok = (credits_q < CntW'(RspDepth));
    assign eligible  = req_valid_i & (req_we_i | {NumReq{credit_ok}});

    always_comb begin
        int unsigned idx;
        rid_t        idx_w;
        idx     = 0;
        idx_w   = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            idx   = (32'(rr_q) + k) % NumReq;
            idx_w = rid_t'(idx);
            if (!gnt_any && eligible[idx_w]) begin
                gnt_any = 1'b1;
                gnt_idx = idx_w;
            end
        end
    end

    assign gnt    = rst_ni && gnt_any;
    assign gnt_we = req_we_i[gnt_idx];
    assign rd_gnt = gnt && !gnt_we;

    always_comb begin
        req_ready_o = '0;
        if (gnt) req_ready_o[gnt_idx] = 1'b1;
    end

    assign sram_req_o   = gnt;
    assign sram_we_o    = gnt && gnt_we;
    assign sram_addr_o  = gnt ? req_addr_i[gnt_idx]  : '0;
    assign sram_wdata_o = gnt ? req_wdata_i[gnt_idx] : '0;
    assign sram_be_o    = gnt ? req_be_i[gnt_idx]    : '0;

    always_comb begin
        rr_d = rr_q;
        if (gnt) begin
            rr_d = (gnt_idx == rid_t'(NumReq - 1)) ? '0 : gnt_idx + 1'b1;
        end
        pipe_vld_d    = pipe_vld_q;
        pipe_id_d     = pipe_id_q;
        pipe_vld_d[0] = rd_gnt;
        pipe_id_d[0]  = gnt_idx;
        for (int unsigned i = 1; i < Latency; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_id_d[i]  = pipe_id_q[i-1];
        end
        credits_d = credits_q + CntW'(rd_gnt) - CntW'(pop);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            credits_q  <= '0;
            rr_q       <= '0;
            pipe_vld_q <= '0;
            pipe_id_q  <= '0;
        end else begin
            credits_q  <= credits_d;
            rr_q       <= rr_d;
            pipe_vld_q <= pipe_vld_d;
            pipe_id_q  <= pipe_id_d;
        end
    end

    assign buf_in = '{id: pipe_id_q[Latency-1], rdata: sram_rdata_i};

    axi_llc_data_sched_rsp_buf #(
        .Depth (RspDepth),
        .buf_t (buf_t)
    ) i_rsp_buf (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (pipe_vld_q[Latency-1]),
        .data_i  (buf_in),
        .valid_o (buf_valid),
        .ready_i (rsp_ready_i && rst_ni),
        .data_o  (buf_out)
    );

    assign rsp_valid_o = rst_ni && buf_valid;
    assign pop         = rsp_valid_o && rsp_ready_i;
    assign rsp_id_o    = rst_ni ? buf_out.id    : '0;
    assign rsp_rdata_o = rst_ni ? buf_out.rdata : '0;

`ifdef AXI_LLC_DATA_SCHED_PERF_EN
    logic [31:0] perf_rd_q, perf_rd_d;
    logic [31:0] perf_wr_q, perf_wr_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        stall;

    assign stall = |(req_valid_i & ~req_ready_o);

    always_comb begin
        perf_rd_d    = sat_inc32(perf_rd_q, rd_gnt);
        perf_wr_d    = sat_inc32(perf_wr_q, gnt && gnt_we);
        perf_stall_d = sat_inc32(perf_stall_q, stall);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            perf_rd_q    <= '0;
            perf_wr_q    <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_rd_q    <= perf_rd_d;
            perf_wr_q    <= perf_wr_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_rd_o    = perf_rd_q;
    assign perf_wr_o    = perf_wr_q;
    assign perf_stall_o = perf_stall_q;
`else
    assign perf_rd_o    = '0;
    assign perf_wr_o    = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_axi_llc_data_sram_sched.sv
// Self-checking bench for axi_llc_data_sram_sched with a 1-cycle SRAM model.
// Perf checks depend on AXI_LLC_DATA_SCHED_PERF_EN.
module tb_axi_llc_data_sram_sched;

    localparam int NR = 3;
    localparam int AW = 10;
    localparam int DW = 128;
    localparam int BW = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NR-1:0]        req_valid, req_ready, req_we;
    logic [NR-1:0][AW-1:0] req_addr;
    logic [NR-1:0][DW-1:0] req_wdata;
    logic [NR-1:0][BW-1:0] req_be;
    logic                 rsp_valid, rsp_ready;
    logic [1:0]           rsp_id;
    logic [DW-1:0]        rsp_rdata;
    logic                 sram_req, sram_we;
    logic [AW-1:0]        sram_addr;
    logic [DW-1:0]        sram_wdata, sram_rdata;
    logic [BW-1:0]        sram_be;
    logic [31:0]          perf_rd, perf_wr, perf_stall;

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    logic [DW-1:0] sram_mem [1024];
    logic [DW-1:0] ref_mem  [1024];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    axi_llc_data_sram_sched dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_be_i     (req_be),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_id_o     (rsp_id),
        .rsp_rdata_o  (rsp_rdata),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata),
        .perf_rd_o    (perf_rd),
        .perf_wr_o    (perf_wr),
        .perf_stall_o (perf_stall)
    );

    function automatic logic [DW-1:0] init_word(input int unsigned a);
        return {32'hDEADBEEF ^ 32'(a), 32'hCAFEF00D,
                32'h12345678, 32'h000000A0 + 32'(a)};
    endfunction

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end
    end

    // SRAM model, read latency 1
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < BW; b++)
                    if (sram_be[b]) sram_mem[sram_addr][b*8 +: 8] = sram_wdata[b*8 +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Scoreboard: expectations pushed on read grants, popped on response handshakes
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (rsp_valid && rsp_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected id=%0d rdata=%h", rsp_id, rsp_rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_id !== e.id || rsp_rdata !== e.rdata) begin
                        errors++;
                        $display("FAIL sb_rsp got id=%0d rdata=%h want id=%0d rdata=%h",
                                 rsp_id, rsp_rdata, e.id, e.rdata);
                    end
                end
            end
            for (int i = 0; i < NR; i++) begin
                if (req_ready[i] && req_valid[i]) begin
                    if (req_we[i]) begin
                        for (int b = 0; b < BW; b++)
                            if (req_be[i][b]) ref_mem[req_addr[i]][b*8 +: 8] = req_wdata[i][b*8 +: 8];
                    end else begin
                        exp_q.push_back('{id: 2'(i), rdata: ref_mem[req_addr[i]]});
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = 3'b111;
        req_we    = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000 || sram_req !== 1'b0) begin
            errors++;
            $display("FAIL rst_ready got ready=%b req=%b want 000/0", req_ready, sram_req);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_rdata !== '0) begin
            errors++;
            $display("FAIL rst_rsp got v=%b id=%0d rdata=%h want 0", rsp_valid, rsp_id, rsp_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (perf_rd !== 0 || perf_wr !== 0 || perf_stall !== 0) begin
            errors++;
            $display("FAIL rst_perf got %0d %0d %0d want 0", perf_rd, perf_wr, perf_stall);
        end
        tick();
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    task automatic test_single_read();
        do_reset();
        rsp_ready   = 1'b1;
        req_we      = '0;
        req_addr[0] = 10'd5;
        req_valid   = 3'b001;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001 || sram_req !== 1'b1 || sram_addr !== 10'd5) begin
            errors++;
            $display("FAIL sr_grant got ready=%b req=%b addr=%0d want 001/1/5",
                     req_ready, sram_req, sram_addr);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_rdata[7:0] !== 8'hA5) begin
            errors++;
            $display("FAIL sr_rsp got v=%b id=%0d rdata=%h want 1/0/..a5",
                     rsp_valid, rsp_id, rsp_rdata);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL sr_idle got v=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] want;
        do_reset();
        rsp_ready = 1'b1;
        req_we    = '0;
        req_addr  = {10'd12, 10'd11, 10'd10};
        req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            want = 3'(1 << (k % 3));
            @(negedge clk);
            checks++;
            if (req_ready !== want) begin
                errors++;
                $display("FAIL rr_grant%0d got %b want %b", k, req_ready, want);
            end
            tick();
        end
        req_valid = '0;
        repeat (3) tick();
`ifdef AXI_LLC_DATA_SCHED_PERF_EN
        checks++;
        if (perf_rd !== 32'd6 || perf_wr !== 32'd0 || perf_stall !== 32'd6) begin
            errors++;
            $display("FAIL rr_perf got rd=%0d wr=%0d st=%0d want 6/0/6",
                     perf_rd, perf_wr, perf_stall);
        end
`endif
    endtask

    task automatic test_credit_stall();
        do_reset();
        rsp_ready   = 1'b0;
        req_we      = '0;
        req_addr[0] = 10'd20;
        req_addr[2] = 10'd22;
        req_valid   = 3'b101;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL cs_g0 got %b want 001", req_ready);
        end
        tick();
        req_valid = 3'b100;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b100) begin
            errors++;
            $display("FAIL cs_g2 got %b want 100", req_ready);
        end
        tick();
        req_valid    = 3'b011;
        req_we       = 3'b010;
        req_addr[0]  = 10'd21;
        req_addr[1]  = 10'd9;
        req_wdata[1] = '1;
        req_be[1]    = '1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010 || sram_we !== 1'b1) begin
            errors++;
            $display("FAIL cs_wr got ready=%b we=%b want 010/1", req_ready, sram_we);
        end
        tick();
        req_valid = 3'b001;
        req_we    = '0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000) begin
            errors++;
            $display("FAIL cs_full got %b want 000", req_ready);
        end
        tick();
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL cs_pop_same got ready=%b v=%b id=%0d want 000/1/0",
                     req_ready, rsp_valid, rsp_id);
        end
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL cs_next got %b want 001", req_ready);
        end
        tick();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] want;
        want = init_word(7);
        want[15:0] = 16'h1234;
        do_reset();
        rsp_ready    = 1'b1;
        req_we       = 3'b010;
        req_addr[1]  = 10'd7;
        req_wdata[1] = 128'h1234;
        req_be[1]    = 16'h0003;
        req_valid    = 3'b010;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b010 || sram_we !== 1'b1 || sram_be !== 16'h0003) begin
            errors++;
            $display("FAIL wr_grant got ready=%b we=%b be=%h want 010/1/0003",
                     req_ready, sram_we, sram_be);
        end
        tick();
        req_we      = '0;
        req_addr[0] = 10'd7;
        req_valid   = 3'b001;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL wr_rd_grant got %b want 001", req_ready);
        end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== want) begin
            errors++;
            $display("FAIL wr_rdata got v=%b %h want 1 %h", rsp_valid, rsp_rdata, want);
        end
        tick();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rsp_ready   = 1'b0;
        req_we      = '0;
        req_addr[0] = 10'd30;
        req_addr[1] = 10'd31;
        req_valid   = 3'b011;
        tick();
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 3'b000) begin
            errors++;
            $display("FAIL mr_during got v=%b ready=%b want 0/000", rsp_valid, req_ready);
        end
        tick();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL mr_after got v=%b want 0", rsp_valid);
        end
        checks++;
        if (perf_rd !== 0 || perf_wr !== 0 || perf_stall !== 0) begin
            errors++;
            $display("FAIL mr_perf got %0d %0d %0d want 0", perf_rd, perf_wr, perf_stall);
        end
        tick();
        req_valid = 3'b111;
        @(negedge clk);
        checks++;
        if (req_ready !== 3'b001) begin
            errors++;
            $display("FAIL mr_rrptr got %b want 001", req_ready);
        end
        tick();
        req_valid = '0;
        repeat (3) tick();
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_credit_stall();
        test_write_read();
        test_reset_midflight();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
